// File: rtl/pipeline_ctrl.sv
// Pipeline controller: per-stage latch enables/flushes, PC redirect with deferral, halt drain.
// Optional PIPECTRL_PERF_EN adds saturating stall_cnt / flush_cnt outputs.
module pipeline_ctrl #(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            nRST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic            mem_dmemREN,
  input  logic            mem_dmemWEN,
  input  logic            hazard,
  input  logic            branch,
  input  logic            jump,
  input  logic [PC_W-1:0] branch_target,
  input  logic [PC_W-1:0] jump_target,
  input  logic            halt_mem,
  output logic            pc_en,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            ifid_en,
  output logic            idex_en,
  output logic            exmem_en,
  output logic            memwb_en,
  output logic            ifid_flush,
  output logic            idex_flush,
  output logic            halt,
`ifdef PIPECTRL_PERF_EN
  output logic [31:0]     stall_cnt,
  output logic [31:0]     flush_cnt,
`endif
  output logic [1:0]      state_dbg
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    REDIR  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PC_W-1:0] pend_q, pend_d;
  logic            mem_req, adv, redir_req;
  logic [PC_W-1:0] sel_target;

  assign mem_req    = mem_dmemREN | mem_dmemWEN;
  assign adv        = ihit & (~mem_req | dhit);
  assign redir_req  = branch | jump;
  assign sel_target = branch ? branch_target : jump_target;
  assign state_dbg  = state_q;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= RUN;
      pend_q  <= RESET_PC;
      halt    <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      halt    <= (state_d == HALTED);
    end
  end

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pc_en       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = pend_q;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    case (state_q)
      RUN: begin
        exmem_en = adv;
        memwb_en = adv;
        pc_en    = adv & ~hazard;
        ifid_en  = adv & ~hazard;
        idex_en  = adv & ~hazard;
        if (hazard) begin
          // Bubble into ID/EX; branch/jump are re-presented after the stall.
          if (adv) begin
            idex_flush = 1'b1;
            idex_en    = 1'b1;
          end
        end else if (redir_req) begin
          if (adv) begin
            redirect    = 1'b1;
            redirect_pc = sel_target;
            ifid_flush  = 1'b1;
          end else begin
            pend_d  = sel_target;
            state_d = REDIR;
          end
        end
        if (halt_mem && adv) state_d = HALTED;
      end
      REDIR: begin
        exmem_en = adv;
        memwb_en = adv;
        pc_en    = adv;
        ifid_en  = adv;
        idex_en  = adv;
        if (adv) begin
          redirect    = 1'b1;
          redirect_pc = pend_q;
          ifid_flush  = 1'b1;
          state_d     = RUN;
        end
        if (halt_mem && adv) state_d = HALTED;
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: state_d = RUN;
    endcase
    // Outputs are quiet for the whole reset window, not just after the first edge.
    if (!nRST) begin
      pc_en       = 1'b0;
      redirect    = 1'b0;
      redirect_pc = RESET_PC;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
    end
  end

`ifdef PIPECTRL_PERF_EN
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (state_q != HALTED && !pc_en && stall_cnt != 32'hFFFF_FFFF)
        stall_cnt <= stall_cnt + 32'd1;
      if (state_q != HALTED && (ifid_flush || idex_flush) && flush_cnt != 32'hFFFF_FFFF)
        flush_cnt <= flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed self-checking bench for pipeline_ctrl; expected values are hand-computed.
module tb_pipeline_ctrl;

  localparam int PC_W = 32;

  logic            CLK = 1'b0;
  logic            nRST;
  logic            ihit, dhit, mem_dmemREN, mem_dmemWEN;
  logic            hazard, branch, jump, halt_mem;
  logic [PC_W-1:0] branch_target, jump_target;
  logic            pc_en, redirect, ifid_en, idex_en, exmem_en, memwb_en;
  logic            ifid_flush, idex_flush, halt;
  logic [PC_W-1:0] redirect_pc;
  logic [1:0]      state_dbg;
`ifdef PIPECTRL_PERF_EN
  logic [31:0]     stall_cnt, flush_cnt;
  logic [31:0]     stall_snap;
`endif

  int checks = 0;
  int errors = 0;
  logic [PC_W-1:0] exp_q[$];
  logic [PC_W-1:0] exp_pc;

  pipeline_ctrl #(.PC_W(PC_W), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .mem_dmemREN(mem_dmemREN), .mem_dmemWEN(mem_dmemWEN),
    .hazard(hazard), .branch(branch), .jump(jump),
    .branch_target(branch_target), .jump_target(jump_target),
    .halt_mem(halt_mem), .pc_en(pc_en), .redirect(redirect),
    .redirect_pc(redirect_pc), .ifid_en(ifid_en), .idex_en(idex_en),
    .exmem_en(exmem_en), .memwb_en(memwb_en), .ifid_flush(ifid_flush),
    .idex_flush(idex_flush), .halt(halt),
`ifdef PIPECTRL_PERF_EN
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
`endif
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Enables packed as {pc_en, ifid_en, idex_en, exmem_en, memwb_en}.
  function automatic logic [31:0] en_vec();
    return {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en};
  endfunction

  function automatic logic [31:0] fl_vec();
    return {29'd0, redirect, ifid_flush, idex_flush};
  endfunction

  task automatic set_idle();
    ihit = 1'b1; dhit = 1'b0; mem_dmemREN = 1'b0; mem_dmemWEN = 1'b0;
    hazard = 1'b0; branch = 1'b0; jump = 1'b0; halt_mem = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
  endtask

  // Move to the next low phase; caller then sets inputs and calls settle.
  task automatic next_cycle();
    @(negedge CLK);
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset with every input high.
    nRST = 1'b0;
    ihit = 1; dhit = 1; mem_dmemREN = 1; mem_dmemWEN = 1;
    hazard = 1; branch = 1; jump = 1; halt_mem = 1;
    branch_target = 32'hFFFF_FFFF; jump_target = 32'hFFFF_FFFF;
    next_cycle(); settle();
    check("reset_en", en_vec(), 32'h0);
    check("reset_flush", fl_vec(), 32'h0);
    check("reset_halt", {31'd0, halt}, 32'd0);
    check("reset_rpc", redirect_pc, 32'h0);
    next_cycle(); set_idle(); nRST = 1'b1; settle();
    check("run_state", {30'd0, state_dbg}, 32'd0);
    check("run_en", en_vec(), 32'h1F);
    check("run_flush", fl_vec(), 32'h0);

    // Load-use stall.
    next_cycle(); hazard = 1'b1; settle();
    check("lu_en", en_vec(), 32'b00111);
    check("lu_flush", fl_vec(), 32'b001);
    next_cycle(); hazard = 1'b0; settle();
    check("lu_after_en", en_vec(), 32'h1F);

    // Dcache miss for 3 cycles, then hit.
    for (int i = 0; i < 3; i++) begin
      next_cycle(); mem_dmemREN = 1'b1; dhit = 1'b0; settle();
      check("dmiss_en", en_vec(), 32'h0);
    end
    next_cycle(); dhit = 1'b1; settle();
    check("dhit_en", en_vec(), 32'h1F);
    next_cycle(); ihit = 1'b0; settle();
    check("dhit_no_ihit_en", en_vec(), 32'h0);
    next_cycle(); set_idle(); mem_dmemWEN = 1'b1; settle();
    check("store_miss_en", en_vec(), 32'h0);

    // Deferred redirect: branch seen while fetch stalls.
    next_cycle(); set_idle(); ihit = 1'b0; branch = 1'b1; branch_target = 32'h40;
    exp_q.push_back(32'h40); settle();
    check("defer0_flush", fl_vec(), 32'h0);
    check("defer0_en", en_vec(), 32'h0);
    next_cycle(); settle();
    check("defer1_state", {30'd0, state_dbg}, 32'd1);
    check("defer1_flush", fl_vec(), 32'h0);
    next_cycle(); branch = 1'b0; branch_target = 32'h99; ihit = 1'b1; settle();
    exp_pc = exp_q.pop_front();
    check("defer2_flush", fl_vec(), 32'b110);
    check("defer2_rpc", redirect_pc, exp_pc);
    check("defer2_en", en_vec(), 32'h1F);
    next_cycle(); settle();
    check("defer3_flush", fl_vec(), 32'h0);
    check("defer3_state", {30'd0, state_dbg}, 32'd0);

    // Priority: branch over jump, hazard over both.
    next_cycle(); branch = 1; jump = 1; branch_target = 32'h80; jump_target = 32'hC0; settle();
    check("prio_flush", fl_vec(), 32'b110);
    check("prio_rpc", redirect_pc, 32'h80);
    check("prio_pc_en", {31'd0, pc_en}, 32'd1);
    next_cycle(); branch = 0; settle();
    check("jump_rpc", redirect_pc, 32'hC0);
    next_cycle(); branch = 1; hazard = 1; settle();
    check("prio_hz_flush", fl_vec(), 32'b001);
    check("prio_hz_en", en_vec(), 32'b00111);

    // Reset while a redirect is pending discards the target.
    next_cycle(); set_idle(); ihit = 0; jump = 1; jump_target = 32'h44; settle();
    next_cycle(); nRST = 1'b0; settle();
    check("rst_redir_state", {30'd0, state_dbg}, 32'd0);
    next_cycle(); set_idle(); nRST = 1'b1; settle();
    check("rst_redir_flush", fl_vec(), 32'h0);
    check("rst_redir_rpc", redirect_pc, 32'h0);

    // Halt drain.
    next_cycle(); halt_mem = 1'b1; settle();
    check("halt_pre", {31'd0, halt}, 32'd0);
    check("halt_pre_en", en_vec(), 32'h1F);
    next_cycle(); halt_mem = 1'b0; settle();
    check("halt_set", {31'd0, halt}, 32'd1);
    check("halt_state", {30'd0, state_dbg}, 32'd2);
`ifdef PIPECTRL_PERF_EN
    stall_snap = stall_cnt;
`endif
    for (int i = 0; i < 4; i++) begin
      next_cycle(); ihit = i[0]; branch = 1'b1; settle();
      check("halted_en", en_vec(), 32'h0);
      check("halted_flush", fl_vec(), 32'h0);
      check("halted_hold", {31'd0, halt}, 32'd1);
    end
`ifdef PIPECTRL_PERF_EN
    check("halted_stall_cnt", stall_cnt, stall_snap);
`endif
    next_cycle(); nRST = 1'b0; settle();
    check("halt_cleared", {31'd0, halt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
